// File: rtl/matrix_mac_writer_if.sv
// Bus bundle between the matrix MAC engine and the A/B read memories and C write port.
// The engine side uses the master modport; the memory/controller side uses slave.
interface matrix_mac_writer_if #(
    parameter int DW = 32,
    parameter int AW = 7
);
    logic          start;
    logic [DW-1:0] a_data;
    logic [DW-1:0] b_data;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [AW-1:0] c_waddr;
    logic [DW-1:0] c_wdata;
    logic          c_we;
    logic          busy;
    logic          done;

    modport master (
        input  start, a_data, b_data,
        output a_addr, b_addr, c_waddr, c_wdata, c_we, busy, done
    );

    modport slave (
        output start, a_data, b_data,
        input  a_addr, b_addr, c_waddr, c_wdata, c_we, busy, done
    );
endinterface

// File: rtl/matrix_mac_writer.sv
// Serial C = A x B engine for NxN row-major matrices: one MAC per cycle, one C write per element.
// Addresses are tracked with running counters rather than multipliers.
module matrix_mac_writer #(
    parameter int N  = 3,
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic               clk,
    input  logic               rst,
    matrix_mac_writer_if.master mm
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LP_N    = AW'(N);
    localparam logic [AW-1:0] LP_NM1  = AW'(N - 1);
    localparam logic [AW-1:0] LP_ONE  = AW'(1);
    localparam logic [AW-1:0] LP_ZERO = AW'(0);

    state_t        r_state;
    logic [AW-1:0] r_i;
    logic [AW-1:0] r_j;
    logic [AW-1:0] r_k;
    logic [AW-1:0] r_row_base;   // i*N
    logic [AW-1:0] r_a_addr;     // i*N + k
    logic [AW-1:0] r_b_addr;     // k*N + j
    logic [AW-1:0] r_c_waddr;    // i*N + j
    logic [DW-1:0] r_acc;
    logic          r_c_we;
    logic          r_busy;
    logic          r_done;

    logic [DW-1:0] w_prod;
    logic          w_k_last;
    logic          w_j_last;
    logic          w_i_last;

    assign w_prod   = mm.a_data * mm.b_data;
    assign w_k_last = (r_k == LP_NM1);
    assign w_j_last = (r_j == LP_NM1);
    assign w_i_last = (r_i == LP_NM1);

    // Control FSM, index counters, address trackers, accumulator and output flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_i        <= LP_ZERO;
            r_j        <= LP_ZERO;
            r_k        <= LP_ZERO;
            r_row_base <= LP_ZERO;
            r_a_addr   <= LP_ZERO;
            r_b_addr   <= LP_ZERO;
            r_c_waddr  <= LP_ZERO;
            r_acc      <= {DW{1'b0}};
            r_c_we     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mm.start) begin
                        r_state    <= ST_MAC;
                        r_i        <= LP_ZERO;
                        r_j        <= LP_ZERO;
                        r_k        <= LP_ZERO;
                        r_row_base <= LP_ZERO;
                        r_a_addr   <= LP_ZERO;
                        r_b_addr   <= LP_ZERO;
                        r_c_waddr  <= LP_ZERO;
                        r_acc      <= {DW{1'b0}};
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + w_prod;
                    if (!w_k_last) begin
                        r_k      <= r_k + LP_ONE;
                        r_a_addr <= r_a_addr + LP_ONE;
                        r_b_addr <= r_b_addr + LP_N;
                    end else begin
                        // k wraps to 0, so the addresses fall back to the row/column start.
                        r_k      <= LP_ZERO;
                        r_a_addr <= r_row_base;
                        r_b_addr <= r_j;
                        r_state  <= ST_WRITE;
                        r_c_we   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_acc  <= {DW{1'b0}};
                    r_c_we <= 1'b0;
                    if (!w_j_last) begin
                        r_j       <= r_j + LP_ONE;
                        r_b_addr  <= r_j + LP_ONE;
                        r_a_addr  <= r_row_base;
                        r_c_waddr <= r_c_waddr + LP_ONE;
                        r_state   <= ST_MAC;
                    end else if (!w_i_last) begin
                        r_j        <= LP_ZERO;
                        r_i        <= r_i + LP_ONE;
                        r_row_base <= r_row_base + LP_N;
                        r_a_addr   <= r_row_base + LP_N;
                        r_b_addr   <= LP_ZERO;
                        r_c_waddr  <= r_c_waddr + LP_ONE;
                        r_state    <= ST_MAC;
                    end else begin
                        r_i        <= LP_ZERO;
                        r_j        <= LP_ZERO;
                        r_row_base <= LP_ZERO;
                        r_a_addr   <= LP_ZERO;
                        r_b_addr   <= LP_ZERO;
                        r_c_waddr  <= LP_ZERO;
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_c_we  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign mm.a_addr  = r_a_addr;
    assign mm.b_addr  = r_b_addr;
    assign mm.c_waddr = r_c_waddr;
    assign mm.c_wdata = r_acc;
    assign mm.c_we    = r_c_we;
    assign mm.busy    = r_busy;
    assign mm.done    = r_done;
endmodule
